// File: rtl/fetcher_if.sv
// fetcher_if: PC-stage, memory-controller and instruction-queue signals of the fetch stage.
interface fetcher_if;
  logic        ena;
  logic [31:0] in_pc;
  logic        in_pc_taken;
  logic        in_rollback;
  logic        out_pc_ena;
  logic [31:0] out_last_pc;
  logic [31:0] out_last_inst;
  logic        out_mem_req;
  logic [31:0] out_mem_addr;
  logic        in_mem_ready;
  logic [31:0] in_mem_data;
  logic        in_queue_full;
  logic        out_inst_valid;
  logic [31:0] out_inst;
  logic [31:0] out_inst_pc;
  logic        out_inst_taken;
  modport master (
    input  ena, in_pc, in_pc_taken, in_rollback, in_mem_ready, in_mem_data, in_queue_full,
    output out_pc_ena, out_last_pc, out_last_inst, out_mem_req, out_mem_addr,
           out_inst_valid, out_inst, out_inst_pc, out_inst_taken
  );
  modport slave (
    output ena, in_pc, in_pc_taken, in_rollback, in_mem_ready, in_mem_data, in_queue_full,
    input  out_pc_ena, out_last_pc, out_last_inst, out_mem_req, out_mem_addr,
           out_inst_valid, out_inst, out_inst_pc, out_inst_taken
  );
endinterface

// File: rtl/fetcher.sv
// fetcher: instruction fetch via optional direct-mapped I-cache (enabled by `define ICACHE_EN)
// or memory controller; emits one instruction per pulse and discards in-flight fetches on rollback.
module fetcher #(
  parameter int ICACHE_INDEX_BITS = 6
) (
  input logic       clk,
  input logic       rst,
  fetcher_if.master bus
);
  typedef enum logic [1:0] {IDLE, MEM, HOLD, PCUPD} state_t;
  state_t      state_q;
  logic [31:0] pc_q, hold_q, last_pc_q, last_inst_q;
  logic        mem_req_q, valid_q, discard_q;
  logic        hit;
  logic [31:0] hit_data;
`ifdef ICACHE_EN
  localparam int N = ICACHE_INDEX_BITS;
  localparam int L = 1 << N;
  logic [L-1:0]    vld_q;
  logic [29-N:0]   tag_q [L];
  logic [31:0]     data_q [L];
  logic [N-1:0]    rd_idx, wr_idx;
  logic            fill;
  assign rd_idx   = bus.in_pc[N+1:2];
  assign wr_idx   = pc_q[N+1:2];
  assign fill     = bus.ena && state_q == MEM && bus.in_mem_ready;
  assign hit      = vld_q[rd_idx] && tag_q[rd_idx] == bus.in_pc[31:N+2];
  assign hit_data = data_q[rd_idx];
  always_ff @(posedge clk)
    if (fill) begin
      tag_q[wr_idx]  <= pc_q[31:N+2];
      data_q[wr_idx] <= bus.in_mem_data;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) vld_q <= '0;
    else if (fill) vld_q[wr_idx] <= 1'b1;
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      hold_q      <= '0;
      last_pc_q   <= '0;
      last_inst_q <= '0;
      mem_req_q   <= 1'b0;
      valid_q     <= 1'b0;
      discard_q   <= 1'b0;
    end else if (bus.ena) begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE:
          if (!bus.in_rollback) begin
            if (!hit) begin
              pc_q      <= bus.in_pc;
              mem_req_q <= 1'b1;
              state_q   <= MEM;
            end else if (!bus.in_queue_full) begin
              valid_q     <= 1'b1;
              last_pc_q   <= bus.in_pc;
              last_inst_q <= hit_data;
              state_q     <= PCUPD;
            end
          end
        MEM:
          if (bus.in_mem_ready) begin
            mem_req_q <= 1'b0;
            hold_q    <= bus.in_mem_data;
            if (discard_q || bus.in_rollback) begin
              discard_q <= 1'b0;
              state_q   <= IDLE;
            end else if (!bus.in_queue_full) begin
              valid_q     <= 1'b1;
              last_pc_q   <= pc_q;
              last_inst_q <= bus.in_mem_data;
              state_q     <= PCUPD;
            end else state_q <= HOLD;
          end else if (bus.in_rollback) discard_q <= 1'b1;
        HOLD:
          if (bus.in_rollback) state_q <= IDLE;
          else if (!bus.in_queue_full) begin
            valid_q     <= 1'b1;
            last_pc_q   <= pc_q;
            last_inst_q <= hold_q;
            state_q     <= PCUPD;
          end
        default: state_q <= IDLE;
      endcase
    end
  assign bus.out_pc_ena     = valid_q;
  assign bus.out_inst_valid = valid_q;
  assign bus.out_last_pc    = last_pc_q;
  assign bus.out_last_inst  = last_inst_q;
  assign bus.out_inst_pc    = last_pc_q;
  assign bus.out_inst       = last_inst_q;
  assign bus.out_mem_req    = mem_req_q;
  assign bus.out_mem_addr   = {pc_q[31:2], 2'b00};
  assign bus.out_inst_taken = bus.in_pc_taken;
endmodule

// File: tb/tb_fetcher.sv
// tb_fetcher: directed fetch sequence with an emit scoreboard; cache-hit expectations depend on ICACHE_EN.
module tb_fetcher;
  logic clk = 1'b0;
  logic rst = 1'b1;
  fetcher_if bus();
  fetcher dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct { logic [31:0] pc, inst; } exp_t;
  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  logic prev_v = 1'b0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (bus.ena && !rst) begin
      chk("pc_ena_eq_valid", bus.out_pc_ena, bus.out_inst_valid);
      if (bus.out_inst_valid) begin
        chk("no_back_to_back", prev_v, 0);
        chk("taken", bus.out_inst_taken, bus.in_pc_taken);
        if (q.size() == 0) chk("unexpected_emit", bus.out_inst_valid, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("inst_pc", bus.out_inst_pc, e.pc);
          chk("inst", bus.out_inst, e.inst);
          chk("last_pc", bus.out_last_pc, e.pc);
          chk("last_inst", bus.out_last_inst, e.inst);
        end
      end
      prev_v <= bus.out_inst_valid;
    end
  task automatic wait_req(input logic [31:0] pc);
    int n = 0;
    bus.in_pc = pc;
    step();
    while (!bus.out_mem_req && n < 20) begin
      step();
      n++;
    end
    chk("mem_req_seen", bus.out_mem_req, 1);
    chk("mem_addr", bus.out_mem_addr, {pc[31:2], 2'b00});
  endtask
  task automatic mem_fetch(input logic [31:0] pc, input logic [31:0] data, input int dly);
    wait_req(pc);
    repeat (dly) step();
    chk("req_held", bus.out_mem_req, 1);
    bus.in_mem_ready = 1'b1;
    bus.in_mem_data  = data;
    q.push_back('{pc, data});
    step();
    bus.in_mem_ready = 1'b0;
    chk("miss_emit", bus.out_inst_valid, 1);
    chk("req_dropped", bus.out_mem_req, 0);
    step();
    chk("pcupd_bubble", bus.out_inst_valid, 0);
  endtask
  task automatic hit_fetch(input logic [31:0] pc, input logic [31:0] data);
`ifdef ICACHE_EN
    bus.in_pc = pc;
    q.push_back('{pc, data});
    step();
    chk("hit_emit", bus.out_inst_valid, 1);
    chk("hit_no_req", bus.out_mem_req, 0);
    step();
    chk("hit_bubble", bus.out_inst_valid, 0);
`else
    mem_fetch(pc, data, 1);
`endif
  endtask
  initial begin
    bus.ena = 1'b1;
    bus.in_pc = '0;
    bus.in_pc_taken = 1'b0;
    bus.in_rollback = 1'b0;
    bus.in_mem_ready = 1'b0;
    bus.in_mem_data = '0;
    bus.in_queue_full = 1'b0;
    step();
    step();
    chk("rst_valid", bus.out_inst_valid, 0);
    chk("rst_pc_ena", bus.out_pc_ena, 0);
    chk("rst_req", bus.out_mem_req, 0);
    chk("rst_addr", bus.out_mem_addr, 0);
    chk("rst_last_pc", bus.out_last_pc, 0);
    chk("rst_last_inst", bus.out_last_inst, 0);
    rst = 1'b0;
    mem_fetch(32'h0, 32'h0000_0013, 3);
    hit_fetch(32'h0, 32'h0000_0013);
    bus.in_pc_taken = 1'b1;
    mem_fetch(32'h104, 32'h1111_0104, 1);
    mem_fetch(32'h204, 32'h2222_0204, 2);
    mem_fetch(32'h104, 32'h3333_0104, 1);
    mem_fetch(32'h206, 32'h4444_0204, 0);
    bus.in_pc_taken = 1'b0;
    wait_req(32'h40);
    step();
    bus.in_rollback = 1'b1;
    step();
    bus.in_rollback = 1'b0;
    chk("rb_req_held", bus.out_mem_req, 1);
    repeat (2) step();
    bus.in_mem_ready = 1'b1;
    bus.in_mem_data = 32'h0000_00AA;
    step();
    bus.in_mem_ready = 1'b0;
    chk("rb_no_emit", bus.out_inst_valid, 0);
    chk("rb_req_drop", bus.out_mem_req, 0);
    hit_fetch(32'h40, 32'h0000_00AA);
    wait_req(32'h8);
    bus.in_queue_full = 1'b1;
    bus.in_mem_ready = 1'b1;
    bus.in_mem_data = 32'h0000_0808;
    step();
    bus.in_mem_ready = 1'b0;
    chk("hold_no_emit", bus.out_inst_valid, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_wait", bus.out_pc_ena, 0);
    end
    bus.in_queue_full = 1'b0;
    q.push_back('{32'h8, 32'h0000_0808});
    step();
    chk("hold_emit", bus.out_inst_valid, 1);
    step();
    chk("hold_bubble", bus.out_inst_valid, 0);
    wait_req(32'h500);
    bus.in_mem_ready = 1'b1;
    bus.in_mem_data = 32'h0000_5005;
    q.push_back('{32'h500, 32'h0000_5005});
    step();
    bus.in_mem_ready = 1'b0;
    bus.ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ena_freeze", bus.out_inst_valid, 1);
    end
    bus.ena = 1'b1;
    step();
    chk("ena_resume", bus.out_inst_valid, 0);
    wait_req(32'h300);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_req", bus.out_mem_req, 0);
    chk("arst_addr", bus.out_mem_addr, 0);
    chk("arst_last_pc", bus.out_last_pc, 0);
    chk("arst_last_inst", bus.out_last_inst, 0);
    rst = 1'b0;
    mem_fetch(32'h0, 32'h0000_0055, 1);
    repeat (2) step();
    chk("scoreboard_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
